// File: rtl/uart_packet_assembler.sv
// Collects UART bytes into 16-byte little-endian packets for the TileLink bridge.
// A partial packet is dropped after TIMEOUT_CYCLES consecutive idle cycles.
//
// state     | meaning
// S_IDLE    | no bytes held
// S_COLLECT | 1..15 bytes held, idle timer running
// S_FULL    | 16 bytes held, packet presented, rx stalled
module uart_packet_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [7:0]   rx_data,
  output logic         packet_valid,
  input  logic         packet_ready,
  output logic [127:0] packet_data,
  output logic         timeout_pulse,
  output logic [15:0]  timeout_count,
  output logic [4:0]   byte_count
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept;
  logic              timeout_fire;

  always_ff @(posedge sysclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    rx_ready     = 1'b1;
    packet_valid = 1'b0;
    accept       = 1'b0;
    timeout_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        accept = rx_valid;
        if (rx_valid) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        accept = rx_valid;
        // an arriving byte always wins over a timeout in the same cycle
        if (rx_valid) begin
          if (byte_count == 5'd15) state_d = S_FULL;
        end else if (idle_cnt == IDLE_LAST) begin
          timeout_fire = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_FULL: begin
        rx_ready     = 1'b0;
        packet_valid = 1'b1;
        if (packet_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      packet_data   <= '0;
      byte_count    <= '0;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      timeout_pulse <= timeout_fire;
      if (accept) begin
        packet_data[{byte_count[3:0], 3'b000} +: 8] <= rx_data;
        byte_count <= byte_count + 5'd1;
      end else if (timeout_fire || (state_q == S_FULL && packet_ready)) begin
        byte_count <= '0;
      end
      if (state_q == S_COLLECT && !accept && !timeout_fire) idle_cnt <= idle_cnt + 1'b1;
      else                                                   idle_cnt <= '0;
      if (timeout_fire && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Bench for uart_packet_assembler: directed scenarios plus random traffic,
// every cycle compared against a byte-count/packet reference model.
module tb_uart_packet_assembler;

  localparam int TO = 100;

  logic         sysclk = 1'b0;
  logic         reset;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   rx_data;
  logic         packet_valid;
  logic         packet_ready;
  logic [127:0] packet_data;
  logic         timeout_pulse;
  logic [15:0]  timeout_count;
  logic [4:0]   byte_count;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: bytes held, packet image, idle run length, timeout stats
  int           m_cnt;
  int           m_idle;
  logic [127:0] m_data;
  logic         m_pulse;
  logic [15:0]  m_tcnt;

  uart_packet_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .packet_valid  (packet_valid),
    .packet_ready  (packet_ready),
    .packet_data   (packet_data),
    .timeout_pulse (timeout_pulse),
    .timeout_count (timeout_count),
    .byte_count    (byte_count)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive one cycle at the falling edge, advance the model, then compare after the next edge
  task automatic cyc(input bit v, input logic [7:0] d, input bit pr, input bit rst);
    rx_valid     = v;
    rx_data      = d;
    packet_ready = pr;
    reset        = rst;
    m_pulse = 1'b0;
    if (rst) begin
      m_cnt = 0; m_idle = 0; m_data = '0; m_tcnt = '0;
    end else if (m_cnt == 16) begin
      if (pr) m_cnt = 0;
    end else if (v) begin
      m_data[m_cnt*8 +: 8] = d;
      m_cnt++;
      m_idle = 0;
    end else if (m_cnt > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_cnt = 0; m_idle = 0; m_pulse = 1'b1;
        if (m_tcnt != 16'hFFFF) m_tcnt++;
      end
    end
    @(negedge sysclk);
    check_val("rx_ready", rx_ready, m_cnt < 16);
    check_val("packet_valid", packet_valid, m_cnt == 16);
    check_val("byte_count", byte_count, m_cnt);
    check_val("packet_data", packet_data, m_data);
    check_val("timeout_pulse", timeout_pulse, m_pulse);
    check_val("timeout_count", timeout_count, m_tcnt);
  endtask

  // 16 back-to-back bytes with the bridge stalled; leaves the block in FULL
  task automatic send_pkt(input bit ramp, output logic [127:0] pk);
    logic [7:0] b;
    pk = '0;
    for (int i = 0; i < 16; i++) begin
      b = ramp ? 8'(i) : 8'($urandom);
      pk[i*8 +: 8] = b;
      cyc(1'b1, b, 1'b0, 1'b0);
    end
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [127:0] pk;
    int r;
    int gap;

    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; packet_ready = 1'b0;
    m_cnt = 0; m_idle = 0; m_data = '0; m_pulse = 1'b0; m_tcnt = '0;
    @(negedge sysclk);
    @(negedge sysclk);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("rst_rx_ready", rx_ready, 1'b1);
    check_val("rst_byte_count", byte_count, 5'd0);
    check_val("rst_packet_data", packet_data, 128'd0);

    // ramp packet with the bridge ready: one-cycle valid, one cycle after byte 15
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    check_val("ramp_valid", packet_valid, 1'b1);
    check_val("ramp_data", packet_data, 128'h0F0E0D0C0B0A09080706050403020100);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("ramp_valid_drop", packet_valid, 1'b0);
    check_val("ramp_data_kept", packet_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // stalled bridge with 0xAA pressing on rx
    send_pkt(1'b0, pk);
    for (int i = 0; i < 50; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check_val("stall_data", packet_data, pk);
    check_val("stall_rx_ready", rx_ready, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check_val("stall_release_cnt", byte_count, 5'd0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check_val("stall_byte0", packet_data[7:0], 8'hAA);
    check_val("stall_cnt1", byte_count, 5'd1);
    send_n(15);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // timeout after 5 bytes
    send_n(5);
    idle_n(TO - 1);
    check_val("to_not_yet", timeout_pulse, 1'b0);
    idle_n(1);
    check_val("to_pulse", timeout_pulse, 1'b1);
    check_val("to_cnt_zero", byte_count, 5'd0);
    check_val("to_count1", timeout_count, 16'd1);
    idle_n(1);
    check_val("to_pulse_once", timeout_pulse, 1'b0);
    send_pkt(1'b0, pk);
    check_val("to_next_pkt", packet_data, pk);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // bytes on idle cycle 99 and on the would-fire cycle 100
    send_n(3);
    idle_n(TO - 2);
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
    check_val("late99_cnt", byte_count, 5'd4);
    idle_n(TO - 1);
    cyc(1'b1, 8'hC5, 1'b0, 1'b0);
    check_val("late100_cnt", byte_count, 5'd5);
    check_val("late100_pulse", timeout_pulse, 1'b0);
    check_val("late100_count", timeout_count, 16'd1);
    send_n(11);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // reset mid-packet
    send_n(9);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("midrst_cnt", byte_count, 5'd0);
    check_val("midrst_data", packet_data, 128'd0);
    check_val("midrst_pulse", timeout_pulse, 1'b0);
    send_pkt(1'b0, pk);
    check_val("midrst_next_pkt", packet_data, pk);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with occasional near-timeout gaps and resets
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
      end else if (r < 3) begin
        gap = $urandom_range(TO - 3, TO + 3);
        for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        cyc($urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // saturation via backdoor preload of the discard counter
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    force dut.timeout_count = 16'hFFFE;
    m_tcnt = 16'hFFFE;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    release dut.timeout_count;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("sat_preload", timeout_count, 16'hFFFE);
    send_n(2);
    idle_n(TO);
    check_val("sat_pulse1", timeout_pulse, 1'b1);
    check_val("sat_reach", timeout_count, 16'hFFFF);
    send_n(2);
    idle_n(TO);
    check_val("sat_pulse2", timeout_pulse, 1'b1);
    check_val("sat_hold", timeout_count, 16'hFFFF);
    idle_n(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
